// File: rtl/seq_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_pkg
// Purpose  : Shared constants for the serial pattern detector: FSM state
//            encoding, the largest supported pattern length, and the width of
//            the window fill counter derived from it.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_detector_pkg;

    // Largest pattern length the detector supports.
    localparam int c_max_width = 32;

    // Fill counter is sized for the largest pattern so every instance shares
    // one width; it only ever counts 0..WIDTH.
    localparam int c_fill_w = $clog2(c_max_width + 1);

    // Detector FSM encoding.
    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : W-bit up counter that sticks at all-ones instead of wrapping.
//            A synchronous clear wins over a simultaneous increment.
// Ports    : clock - rising-edge clock
//            clear - asynchronous active-high reset
//            inc   - add one this cycle (ignored once saturated)
//            clr   - synchronous clear to zero
//            q     - current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector
// Purpose  : Serial pattern detector. Valid bits shift into a WIDTH-bit
//            window at the LSB; once WIDTH bits have been collected a window
//            equal to PATTERN produces a one-cycle registered pulse on x.
//            OVERLAP=1 keeps the window armed after a hit, OVERLAP=0 starts a
//            fresh fill. Optional saturating match counter.
// Macro    : SEQ_DETECTOR_COUNT_EN - when defined, builds the match counter
//            and honours count_clr; otherwise match_count is tied to zero.
// Ports    : clock       - rising-edge clock
//            clear       - asynchronous active-high reset
//            a_valid     - a carries a bit this cycle
//            a           - serial data bit (first bit = PATTERN MSB)
//            restart     - synchronous soft restart of detection
//            count_clr   - synchronous clear of match_count
//            x           - registered one-cycle match pulse
//            armed       - window holds WIDTH valid bits
//            match_count - saturating match count
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             a_valid,
    input  logic             a,
    input  logic             restart,
    input  logic             count_clr,
    output logic             x,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [c_fill_w-1:0] c_full = c_fill_w'(WIDTH);

    logic [0:0]          r_state;
    logic [WIDTH-1:0]    r_win;
    logic [c_fill_w-1:0] r_fill;
    logic                r_x;

    logic                w_accept;
    logic                w_match;
    logic                w_keep_on_match;
    logic [WIDTH-1:0]    w_win_nxt;
    logic [c_fill_w-1:0] w_fill_nxt;

    // restart drops any bit presented with it, so it never yields a match.
    assign w_accept   = a_valid & ~restart;
    assign w_win_nxt  = {r_win[WIDTH-2:0], a};
    assign w_fill_nxt = (r_fill == c_full) ? c_full : r_fill + 1'b1;
    assign w_match    = w_accept && (w_win_nxt == PATTERN) && (w_fill_nxt == c_full);

    // Overlapping mode keeps the full window after a hit so the tail of one
    // match can begin the next; non-overlapping mode refills from scratch.
    generate
        if (OVERLAP != 0) begin : g_overlap
            assign w_keep_on_match = 1'b1;
        end else begin : g_no_overlap
            assign w_keep_on_match = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_win   <= '0;
            r_fill  <= '0;
            r_state <= S_FILL;
            r_x     <= 1'b0;
        end else begin
            r_x <= w_match;
            if (restart) begin
                r_win   <= '0;
                r_fill  <= '0;
                r_state <= S_FILL;
            end else if (a_valid) begin
                // In non-overlap mode the window is refilled completely
                // before it can match again, so its contents are left as-is.
                r_win <= w_win_nxt;
                if (w_match && !w_keep_on_match) begin
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_fill  <= w_fill_nxt;
                    r_state <= (w_fill_nxt == c_full) ? S_ARMED : S_FILL;
                end
            end
        end
    end

    assign x     = r_x;
    assign armed = (r_state == S_ARMED);

`ifdef SEQ_DETECTOR_COUNT_EN
    // The counter advances on the same edge that launches x, so the new
    // count is visible in the same cycle as the pulse.
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (w_match),
        .clr   (count_clr),
        .q     (match_count)
    );
`else
    logic w_unused_count_clr;
    assign w_unused_count_clr = count_clr;
    assign match_count        = '0;
`endif

endmodule
`default_nettype wire

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter WIDTH, default 4: pattern length in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1011, WIDTH bits: target sequence; the MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 selects overlapping detection; 0 selects non-overlapping detection.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 Ports:
- clock, input, 1: sole clock, rising edge.
- clear, input, 1: reset; asynchronous, active-high.
- a_valid, input, 1: a carries a bit this cycle.
- a, input, 1: serial data bit.
- restart, input, 1: synchronous soft restart of detection.
- count_clr, input, 1: synchronous clear of match_count.
- x, output, 1: registered match pulse.
- armed, output, 1: high when the window holds WIDTH valid bits.
- match_count, output, CNT_W: saturating count of matches.

Function
REQ-006 The block SHALL accept a bit only on a rising clock edge where a_valid=1; when a_valid=0 the window, fill count and state SHALL hold.
REQ-007 The block SHALL keep a WIDTH-bit shift window. Each accepted bit SHALL shift in at the LSB.
REQ-008 The block SHALL keep a fill count, 0..WIDTH, that saturates at WIDTH.
REQ-009 The FSM SHALL have two states:
- S_FILL: fill < WIDTH.
- S_ARMED: fill = WIDTH.
REQ-010 FSM transitions SHALL be:
- S_FILL to S_ARMED on the accept that makes fill=WIDTH.
- S_ARMED to S_FILL on restart.
- S_ARMED to S_FILL on a match when OVERLAP=0.
REQ-011 A match SHALL occur on an accept whose updated window equals PATTERN and whose updated fill equals WIDTH.
REQ-012 On a match, x SHALL be 1 in the cycle after the accepting edge, for exactly one cycle; x SHALL be 0 otherwise.
REQ-013 The output armed SHALL equal (state == S_ARMED), registered.
REQ-014 With OVERLAP=1, after a match the window SHALL be retained, the fill SHALL stay WIDTH, and the state SHALL stay S_ARMED.
REQ-015 With OVERLAP=0, after a match the fill SHALL reset to 0 and the state SHALL go to S_FILL; window contents are then don't-care.
REQ-016 On a match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1, with no wrap-around.
REQ-017 restart=1 SHALL zero the window and the fill and SHALL select S_FILL.
- restart has priority over a simultaneous a_valid; that bit is dropped and no match is produced.
- restart SHALL NOT alter match_count.
REQ-018 count_clr=1 SHALL zero match_count and has priority over a simultaneous increment.
REQ-019 restart and count_clr asserted in the same cycle SHALL each take effect.

Reset
REQ-020 clear=1 SHALL immediately, without a clock edge, force: window=0, fill=0, state=S_FILL, x=0, armed=0, match_count=0.
REQ-021 clear asserted mid-sequence SHALL discard all partial progress; no match SHALL be reported for bits accepted before the release of clear.
REQ-022 The first accept SHALL be possible on the first rising edge after clear deasserts.

Configuration
REQ-023 With macro SEQ_DETECTOR_COUNT_EN defined, the match counter and count_clr logic SHALL be compiled in as specified above.
REQ-024 Without SEQ_DETECTOR_COUNT_EN, match_count SHALL be tied to 0, count_clr SHALL be ignored, and x and armed behaviour SHALL be unchanged.

Structure
REQ-025 The state encoding (S_FILL, S_ARMED) SHALL live in shared package seq_detector_pkg, along with the maximum-WIDTH constant (32).
REQ-026 The saturating counter SHALL be a separate sub-module sat_counter, with parameter W and ports clock, clear, inc, clr, q; it is instantiated only when SEQ_DETECTOR_COUNT_EN is defined.

Verification
REQ-027 Overlap: WIDTH=4, PATTERN=1011, OVERLAP=1; stream 1,0,1,1,0,1,1 with a_valid held high -> x pulses after bit 4 and after bit 7; match_count=2.
REQ-028 Non-overlap: the same stream with OVERLAP=0 -> x pulses after bit 4 only; match_count=1; armed is 0 for the cycle after bit 4.
REQ-029 Valid gaps: stream 1,0,1,1 with a_valid=0 for 3 cycles between each bit -> a single x pulse after the final accept; armed rises with that same accept.
REQ-030 Saturation and clear:
- CNT_W=2, OVERLAP=1, stream 1,0,1,1 repeated 5 times -> match_count sticks at 3.
- Then count_clr=1 together with a match -> match_count=0.
REQ-031 Async reset and restart:
- After bits 1,0,1, pulse clear between clock edges -> all outputs 0 immediately; a following single 1 gives no x.
- restart together with a completing bit -> no x.
REQ-032 Macro off: build without SEQ_DETECTOR_COUNT_EN and rerun the REQ-027 stream -> identical x timing; match_count stays 0 throughout.
